wb_rr_arbiter: RTL and testbench

//  Round-robin Wishbone B4 pipelined arbiter sharing one slave port among N masters.

---
 rtl/wb_arb_pkg.sv | 21 ++
 rtl/rr_picker.sv | 28 ++
 rtl/wb_rr_arbiter_chk.sv | 23 ++
 rtl/wb_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int MAX_MASTERS = 8;

   // One-hot (up to 8 bits) to binary index; zero input yields index 0.
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         idx = idx | (oh[i] ? 3'(i) : 3'd0);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_picker #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic found;
   logic hit;

   // Scan offsets 0..N-1 from ptr; the first requesting index wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      hit   = 1'b0;
      for (int off = 0; off < N; off++) begin
         for (int i = 0; i < N; i++) begin
            hit    = !found && req[i] && (i == ((int'(ptr) + off) % N));
            gnt[i] = gnt[i] | hit;
            found  = found | hit;
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter_chk.sv
// Protocol checks for the round-robin arbiter.
module wb_rr_arbiter_chk #(
   parameter int N       = 2,
   parameter int MAX_OUT = 4,
   parameter int CW      = 3
) (
   input logic          clk,
   input logic          rst,
   input logic [N-1:0]  grant,
   input logic          s_cyc,
   input logic          s_stb,
   input logic          s_ack,
   input logic          s_err,
   input logic [CW-1:0] cnt
);

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_stb_in_cyc:   assert property (@(posedge clk) disable iff (rst) s_stb |-> s_cyc);
   a_cnt_bound:    assert property (@(posedge clk) disable iff (rst) cnt <= CW'(MAX_OUT));
   a_no_ack_zero:  assert property (@(posedge clk) disable iff (rst)
                                    (s_cyc && (s_ack || s_err)) |-> (cnt != CW'(0)));

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter: N masters share one slave port.
// A master owns the bus for its whole cycle; ownership changes only after the
// owner drops cyc, with one IDLE cycle between owners.
module wb_rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int N       = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MAX_OUT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      m_cyc,
   input  logic [N-1:0]      m_stb,
   input  logic [N-1:0]      m_we,
   input  logic [N*AW-1:0]   m_adr,
   input  logic [N*DW-1:0]   m_dat_w,
   input  logic [N*DW/8-1:0] m_sel,
   output logic [N-1:0]      m_stall,
   output logic [N-1:0]      m_ack,
   output logic [N-1:0]      m_err,
   output logic [DW-1:0]     m_dat_r,
   output logic              s_cyc,
   output logic              s_stb,
   output logic              s_we,
   output logic [AW-1:0]     s_adr,
   output logic [DW-1:0]     s_dat_w,
   output logic [DW/8-1:0]   s_sel,
   input  logic              s_stall,
   input  logic              s_ack,
   input  logic              s_err,
   input  logic [DW-1:0]     s_dat_r,
   output logic [N-1:0]      grant
);

   localparam int SW = DW / 8;
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(MAX_OUT) + 1;
   localparam logic [CW-1:0] FULL = CW'(MAX_OUT);

   state_t        state_r;
   logic [PW-1:0] ptr_r;
   logic [CW-1:0] cnt_r;
   logic [PW-1:0] owner;
   logic [N-1:0]  pick;
   logic          own_cyc;
   logic          own_stb;
   logic          full;
   logic          accept;
   logic          retire;

   assign owner   = PW'(onehot_to_idx(8'(grant)));
   assign m_dat_r = s_dat_r;

   rr_picker #(.N(N), .PW(PW)) u_pick (
      .req (m_cyc),
      .ptr (ptr_r),
      .gnt (pick)
   );

   // Owner mux and per-master response routing; grant is zero outside BUSY.
   always_comb begin
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      own_cyc = 1'b0;
      own_stb = 1'b0;
      for (int i = 0; i < N; i++) begin
         s_we    = s_we | (m_we[i] & grant[i]);
         s_adr   = s_adr | (m_adr[i*AW +: AW] & {AW{grant[i]}});
         s_dat_w = s_dat_w | (m_dat_w[i*DW +: DW] & {DW{grant[i]}});
         s_sel   = s_sel | (m_sel[i*SW +: SW] & {SW{grant[i]}});
         own_cyc = own_cyc | (m_cyc[i] & grant[i]);
         own_stb = own_stb | (m_stb[i] & grant[i]);
      end
      full    = (cnt_r == FULL);
      s_cyc   = own_cyc;
      s_stb   = own_cyc & own_stb & ~full;
      m_stall = ~grant | (grant & {N{s_stall | full}});
      m_ack   = grant & {N{s_ack & own_cyc}};
      m_err   = grant & {N{s_err & own_cyc}};
      accept  = s_stb & ~s_stall;
      retire  = (s_ack | s_err) & own_cyc & (cnt_r != CW'(0));
   end

   // Ownership FSM with grant, round-robin pointer and outstanding counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         grant   <= '0;
         ptr_r   <= '0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               cnt_r <= '0;
               if (|m_cyc) begin
                  grant   <= pick;
                  state_r <= BUSY;
               end else begin
                  grant <= '0;
               end
            end
            BUSY: begin
               if (!own_cyc) begin
                  // Release (or abort): late responses are dropped since grant clears.
                  state_r <= IDLE;
                  grant   <= '0;
                  cnt_r   <= '0;
                  ptr_r   <= (owner == PW'(N - 1)) ? PW'(0) : owner + PW'(1);
               end else begin
                  cnt_r <= cnt_r + CW'(accept) - CW'(retire);
               end
            end
            default: begin
               state_r <= IDLE;
               grant   <= '0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   wb_rr_arbiter_chk #(.N(N), .MAX_OUT(MAX_OUT), .CW(CW)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .grant (grant),
      .s_cyc (s_cyc),
      .s_stb (s_stb),
      .s_ack (s_ack),
      .s_err (s_err),
      .cnt   (cnt_r)
   );

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter with a latency-programmable slave model.
module tb_wb_rr_arbiter;

   localparam int N = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MAX_OUT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      m_cyc, m_stb, m_we;
   logic [N*AW-1:0]   m_adr;
   logic [N*DW-1:0]   m_dat_w;
   logic [N*DW/8-1:0] m_sel;
   logic [N-1:0]      m_stall, m_ack, m_err;
   logic [DW-1:0]     m_dat_r;
   logic              s_cyc, s_stb, s_we;
   logic [AW-1:0]     s_adr;
   logic [DW-1:0]     s_dat_w;
   logic [DW/8-1:0]   s_sel;
   logic              s_stall, s_ack, s_err;
   logic [DW-1:0]     s_dat_r;
   logic [N-1:0]      grant;

   wb_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
      .m_dat_w(m_dat_w), .m_sel(m_sel),
      .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_w(s_dat_w), .s_sel(s_sel),
      .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
      .grant(grant)
   );

   initial forever #5 clk = ~clk;

   typedef struct { int m; logic [31:0] data; logic err; } exp_t;
   typedef struct { int due; logic [31:0] adr; } sreq_t;

   exp_t  exp_q[$];
   sreq_t sq[$];
   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   int lat = 2;
   int stall_every = 0;
   int outst = 0;
   int max_outst = 0;
   int ack_cnt[N];
   int err_cnt[N];
   logic saw_full = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Slave model: accepts requests, checks the muxed fields, responds after lat edges.
   initial begin
      logic  acc, got;
      logic [3:0] sel_exp;
      sreq_t r;
      s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
      forever begin
         @(posedge clk);
         cyc_n++;
         if (rst) begin
            sq.delete();
            outst = 0;
         end else begin
            acc = s_cyc && s_stb && !s_stall;
            got = s_ack || s_err;
            if (acc) begin
               sel_exp = ~s_adr[5:2];
               chk("s_dat_w", s_dat_w, s_adr ^ 32'h5555_5555);
               chk("s_sel", s_sel, sel_exp);
               chk("s_we", s_we, s_adr[2]);
               r.due = cyc_n + lat;
               r.adr = s_adr;
               sq.push_back(r);
            end
            if (!s_cyc) outst = 0;
            else outst = outst + (acc ? 1 : 0) - ((got && outst > 0) ? 1 : 0);
            if (outst > max_outst) max_outst = outst;
         end
         #1;
         s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
         s_stall = (stall_every != 0) && (cyc_n % stall_every == 0);
         if (!rst && sq.size() > 0 && sq[0].due <= cyc_n) begin
            r = sq.pop_front();
            if (r.adr[31:28] == 4'hE) s_err = 1'b1;
            else s_ack = 1'b1;
            s_dat_r = r.adr ^ 32'hA5A5_A5A5;
         end
      end
   end

   // Monitor: pops the scoreboard on every response and checks routing/stall rules.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (m_ack[i] || m_err[i]) begin
               if (m_ack[i]) ack_cnt[i]++;
               if (m_err[i]) err_cnt[i]++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp", {m_ack[i], m_err[i]}, 2'b00);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_master", i, e.m);
                  chk("resp_err", m_err[i], e.err);
                  chk("resp_ack", m_ack[i], !e.err);
                  if (!e.err) chk("resp_data", m_dat_r, e.data);
               end
            end
            if (!grant[i]) begin
               chk("nonowner_stall", m_stall[i], 1'b1);
               chk("nonowner_resp", {m_ack[i], m_err[i]}, 2'b00);
            end else if (s_cyc) begin
               chk("owner_stall", m_stall[i], s_stall || (outst == MAX_OUT));
               if (outst == MAX_OUT && m_stall[i]) saw_full = 1'b1;
            end
         end
         if (s_cyc) begin
            chk("outstanding", dut.cnt_r, outst);
            if (outst == MAX_OUT) chk("stb_masked", s_stb, 1'b0);
         end
      end
   end

   // Issue one strobe for master m (leaves stb high); pushes the expected response.
   task automatic do_stb(input int m, input logic [31:0] adr);
      logic st;
      exp_t e;
      m_stb[m] = 1'b1;
      m_we[m] = adr[2];
      m_adr[m*AW +: AW] = adr;
      m_dat_w[m*DW +: DW] = adr ^ 32'h5555_5555;
      m_sel[m*4 +: 4] = ~adr[5:2];
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         st = m_stall[m];
         @(posedge clk);
         #1;
         if (!st) begin
            e.m = m;
            e.data = adr ^ 32'hA5A5_A5A5;
            e.err = (adr[31:28] == 4'hE);
            exp_q.push_back(e);
            return;
         end
      end
      chk("stb_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_grant(input int m);
      for (int k = 0; k < 50; k++) begin
         if (grant[m]) return;
         @(posedge clk);
         #1;
      end
      chk("grant_timeout", grant, 2'(1 << m));
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() == 0 && sq.size() == 0) return;
         @(posedge clk);
         #1;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int a1;
      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '0;
      for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; err_cnt[i] = 0; end
      step(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_grant", grant, 2'b00);
      chk("rst_s_cyc", s_cyc, 1'b0);
      chk("rst_s_stb", s_stb, 1'b0);
      chk("rst_m_stall", m_stall, 2'b11);
      chk("rst_m_ack", {m_ack, m_err}, 4'b0000);
      chk("rst_s_adr", s_adr, 32'h0);

      // Single master read, slave latency 2.
      step(1);
      m_cyc[0] = 1'b1;
      @(negedge clk);
      chk("grant_before", grant, 2'b00);
      step(1);
      chk("grant_after_1clk", grant, 2'b01);
      lat = 2;
      do_stb(0, 32'h0000_0100);
      m_stb[0] = 1'b0;
      wait_drain();
      chk("single_acks_m0", ack_cnt[0], 1);
      chk("single_acks_m1", ack_cnt[1], 0);
      m_cyc[0] = 1'b0;
      step(2);

      // Pointer is now 1: simultaneous request goes to m1.
      m_cyc = 2'b11;
      step(1);
      chk("rr_ptr1_grant", grant, 2'b10);
      m_cyc = 2'b00;
      step(2);

      // Reset restores pointer 0, then the contention sequence.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      m_cyc = 2'b11;
      step(1);
      chk("cont_grant_m0", grant, 2'b01);
      chk("cont_m1_stalled", m_stall[1], 1'b1);
      do_stb(0, 32'h0000_0300);
      m_stb[0] = 1'b0;
      wait_drain();
      m_cyc[0] = 1'b0;
      step(1);
      chk("cont_idle_gap", grant, 2'b00);
      step(1);
      chk("cont_grant_m1", grant, 2'b10);
      do_stb(1, 32'h0000_0304);
      m_stb[1] = 1'b0;
      wait_drain();
      m_cyc[1] = 1'b0;
      step(1);
      m_cyc = 2'b11;
      step(1);
      chk("cont_rr_back_m0", grant, 2'b01);
      m_cyc = 2'b00;
      step(2);

      // Pipelined burst on m1, latency 3, reaches MAX_OUT.
      m_cyc[1] = 1'b1;
      wait_grant(1);
      lat = 3;
      max_outst = 0;
      saw_full = 1'b0;
      a1 = ack_cnt[1];
      for (int k = 0; k < 6; k++) do_stb(1, 32'h0000_0200 + 32'(4 * k));
      m_stb[1] = 1'b0;
      wait_drain();
      chk("burst_acks_m1", ack_cnt[1] - a1, 6);
      chk("burst_max_outst", max_outst, MAX_OUT);
      chk("burst_stall_at_full", saw_full, 1'b1);
      m_cyc[1] = 1'b0;
      step(2);

      // Latency 1 keeps count at 2 with accept+ack together; one error; slave stalls.
      m_cyc[0] = 1'b1;
      wait_grant(0);
      lat = 1;
      do_stb(0, 32'h0000_0400);
      do_stb(0, 32'h0000_0404);
      do_stb(0, 32'hE000_0408);
      do_stb(0, 32'h0000_040C);
      do_stb(0, 32'h0000_0410);
      stall_every = 3;
      do_stb(0, 32'h0000_0414);
      do_stb(0, 32'h0000_0418);
      do_stb(0, 32'h0000_041C);
      m_stb[0] = 1'b0;
      wait_drain();
      stall_every = 0;
      chk("err_to_m0", err_cnt[0], 1);
      chk("err_not_m1", err_cnt[1], 0);
      m_cyc[0] = 1'b0;
      step(2);

      // Abort with two outstanding: late acks must not reach any master.
      m_cyc[0] = 1'b1;
      wait_grant(0);
      lat = 3;
      do_stb(0, 32'h0000_0500);
      do_stb(0, 32'h0000_0504);
      m_stb[0] = 1'b0;
      m_cyc[0] = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_s_cyc", s_cyc, 1'b0);
      step(1);
      chk("abort_grant", grant, 2'b00);
      chk("abort_cnt", dut.cnt_r, 0);
      wait_drain();
      step(2);

      // Reset in the middle of a burst with three outstanding.
      m_cyc[0] = 1'b1;
      wait_grant(0);
      lat = 3;
      do_stb(0, 32'h0000_0600);
      do_stb(0, 32'h0000_0604);
      do_stb(0, 32'h0000_0608);
      rst = 1'b1;
      m_stb = '0;
      m_cyc = '0;
      exp_q.delete();
      #1;
      chk("rstmid_s_cyc", s_cyc, 1'b0);
      chk("rstmid_grant", grant, 2'b00);
      chk("rstmid_stall", m_stall, 2'b11);
      chk("rstmid_cnt", dut.cnt_r, 0);
      step(1);
      rst = 1'b0;
      m_cyc[0] = 1'b1;
      step(1);
      chk("rstmid_regrant", grant, 2'b01);
      m_cyc[0] = 1'b0;
      step(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
